// File: rtl/mismatch_tracker_pkg.sv
// Shared definitions for the mismatch tracker.
// Contents:
//   state_e               - tracker state encoding (RUN=0, TRIPPED=1, TIMEOUT=2)
//   DEF_WIDTH             - default counter width
//   DEF_MAX_ERRORS        - default error count at which the tracker trips
//   DEF_TIMEOUT_CYCLES    - default cycle count at which the tracker times out
package mismatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRIPPED = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam int              DEF_WIDTH          = 32;
  localparam longint unsigned DEF_MAX_ERRORS     = 64'd1000;
  localparam longint unsigned DEF_TIMEOUT_CYCLES = 64'd100000;

endpackage

// File: rtl/mismatch_tracker_if.sv
// Sample/status bus of the mismatch tracker.
// Signals:
//   sample_en        - qualifies ref_val/dut_val as a sample this cycle
//   ref_care         - 0 marks the reference as don't-care (sample counts, never mismatches)
//   ref_val          - reference-model output
//   dut_val          - design-under-test output
//   mismatch         - previous cycle's accepted sample mismatched
//   samples          - accepted-sample count
//   errors           - mismatch count
//   first_err_valid  - a mismatch has been counted since reset/clear
//   first_err_cycle  - cycle count at the first counted mismatch
//   state            - tracker state encoding
// Modports: master drives samples and observes status, slave is the tracker.
interface mismatch_tracker_if
  import mismatch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             sample_en;
  logic             ref_care;
  logic             ref_val;
  logic             dut_val;
  logic             mismatch;
  logic [WIDTH-1:0] samples;
  logic [WIDTH-1:0] errors;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_cycle;
  logic [1:0]       state;

  modport master (
    output sample_en, ref_care, ref_val, dut_val,
    input  mismatch, samples, errors, first_err_valid, first_err_cycle, state
  );

  modport slave (
    input  sample_en, ref_care, ref_val, dut_val,
    output mismatch, samples, errors, first_err_valid, first_err_cycle, state
  );

endinterface

// File: rtl/mismatch_tracker_sat_counter.sv
// Saturating up-counter used for the cycle, sample and error counts.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset, zeroes the count
//   clr    - synchronous clear, zeroes the count (wins over inc)
//   inc    - increment enable
//   count  - registered count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  // Next count: clear first, then saturating increment.
  always_comb begin
    count_next_s = count_r;
    if (clr) begin
      count_next_s = {WIDTH{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_next_s = count_r + WIDTH'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mismatch_tracker.sv
// Compares a reference output against a DUT output sample by sample, counts
// samples and mismatches, records when the first mismatch happened, and stops
// counting once too many errors or too many cycles have accumulated.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   areset  - asynchronous active-high reset
//   clear   - synchronous restart of counters and state machine
//   bus     - sample inputs and status outputs (mismatch_tracker_if.slave)
module mismatch_tracker
  import mismatch_pkg::*;
#(
  parameter int              WIDTH          = DEF_WIDTH,
  parameter longint unsigned MAX_ERRORS     = DEF_MAX_ERRORS,
  parameter longint unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               clear,
  mismatch_tracker_if.slave  bus
);

  // Both limits are legal only below the saturation value, so "reaches the
  // limit after this increment" is the same as "sits one below it now and
  // increments"; that avoids needing the counters' next values here.
  localparam logic [WIDTH-1:0] ERR_LAST = WIDTH'(MAX_ERRORS - 64'd1);
  localparam logic [WIDTH-1:0] CYC_LAST = WIDTH'(TIMEOUT_CYCLES - 64'd1);

  state_e           state_r;
  state_e           state_next_s;
  logic             mismatch_r;
  logic             mismatch_next_s;
  logic             fev_r;
  logic             fev_next_s;
  logic [WIDTH-1:0] fec_r;
  logic [WIDTH-1:0] fec_next_s;

  logic             run_s;
  logic             accept_s;
  logic             miss_s;
  logic [WIDTH-1:0] cycle_cnt_s;
  logic [WIDTH-1:0] samples_cnt_s;
  logic [WIDTH-1:0] errors_cnt_s;

  assign run_s    = (state_r == ST_RUN);
  assign accept_s = bus.sample_en & run_s;
  assign miss_s   = accept_s & bus.ref_care & (bus.ref_val ^ bus.dut_val);

  sat_counter #(.WIDTH(WIDTH)) u_cycle (
    .clk   (clk),
    .rst   (areset),
    .clr   (clear),
    .inc   (run_s),
    .count (cycle_cnt_s)
  );

  sat_counter #(.WIDTH(WIDTH)) u_samples (
    .clk   (clk),
    .rst   (areset),
    .clr   (clear),
    .inc   (accept_s),
    .count (samples_cnt_s)
  );

  sat_counter #(.WIDTH(WIDTH)) u_errors (
    .clk   (clk),
    .rst   (areset),
    .clr   (clear),
    .inc   (miss_s),
    .count (errors_cnt_s)
  );

  // Next state, mismatch flag and first-error capture.
  always_comb begin
    state_next_s    = state_r;
    mismatch_next_s = 1'b0;
    fev_next_s      = fev_r;
    fec_next_s      = fec_r;
    if (clear) begin
      state_next_s    = ST_RUN;
      mismatch_next_s = 1'b0;
      fev_next_s      = 1'b0;
      fec_next_s      = {WIDTH{1'b0}};
    end else begin
      mismatch_next_s = miss_s;
      if (miss_s && !fev_r) begin
        fev_next_s = 1'b1;
        fec_next_s = cycle_cnt_s;
      end else begin
        fev_next_s = fev_r;
        fec_next_s = fec_r;
      end
      case (state_r)
        ST_RUN: begin
          // Error trip is checked first so it wins over a coincident timeout.
          if (miss_s && (errors_cnt_s == ERR_LAST)) begin
            state_next_s = ST_TRIPPED;
          end else if (cycle_cnt_s == CYC_LAST) begin
            state_next_s = ST_TIMEOUT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_TRIPPED: state_next_s = ST_TRIPPED;
        ST_TIMEOUT: state_next_s = ST_TIMEOUT;
        default:    state_next_s = ST_RUN;
      endcase
    end
  end

  // State, mismatch and first-error registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r    <= ST_RUN;
      mismatch_r <= 1'b0;
      fev_r      <= 1'b0;
      fec_r      <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_next_s;
      mismatch_r <= mismatch_next_s;
      fev_r      <= fev_next_s;
      fec_r      <= fec_next_s;
    end
  end

  assign bus.mismatch        = mismatch_r;
  assign bus.samples         = samples_cnt_s;
  assign bus.errors          = errors_cnt_s;
  assign bus.first_err_valid = fev_r;
  assign bus.first_err_cycle = fec_r;
  assign bus.state           = state_r;

endmodule

// File: tb/tb_mismatch_tracker.sv
// Scoreboard bench for mismatch_tracker. Three trackers with different
// parameter sets share one stimulus stream; a reference model predicts each
// one's outputs after every edge, and a monitor compares them.
module tb_mismatch_tracker;

  typedef struct {
    longint unsigned cyc;
    longint unsigned smp;
    longint unsigned err;
    longint unsigned fec;
    bit              mis;
    bit              fev;
    longint unsigned st;
  } mdl_t;

  logic clk;
  logic areset;
  logic clear;

  int chk_cnt = 0;
  int err_cnt = 0;

  mdl_t ma, mb, mc;
  mdl_t qa[$];
  mdl_t qb[$];
  mdl_t qc[$];

  mismatch_tracker_if #(.WIDTH(32)) ifa ();
  mismatch_tracker_if #(.WIDTH(32)) ifb ();
  mismatch_tracker_if #(.WIDTH(4))  ifc ();

  mismatch_tracker #(.WIDTH(32), .MAX_ERRORS(64'd1000), .TIMEOUT_CYCLES(64'd100000)) u_a (
    .clk(clk), .areset(areset), .clear(clear), .bus(ifa));
  mismatch_tracker #(.WIDTH(32), .MAX_ERRORS(64'd3), .TIMEOUT_CYCLES(64'd50)) u_b (
    .clk(clk), .areset(areset), .clear(clear), .bus(ifb));
  mismatch_tracker #(.WIDTH(4), .MAX_ERRORS(64'd15), .TIMEOUT_CYCLES(64'd15)) u_c (
    .clk(clk), .areset(areset), .clear(clear), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one edge: counts saturate at 2^w-1, limits from the rules.
  function automatic mdl_t mdl_step(input mdl_t m, input longint unsigned w,
                                    input longint unsigned mx, input longint unsigned to,
                                    input bit clr, input bit en, input bit care,
                                    input bit rv, input bit dv);
    mdl_t n;
    longint unsigned top;
    bit hit;
    n = m;
    top = (64'd1 << w) - 64'd1;
    if (clr) begin
      n = '{default: 0};
    end else if (m.st == 0) begin
      hit = en && care && (rv != dv);
      n.smp = m.smp + (en ? 1 : 0);
      if (n.smp > top) n.smp = top;
      n.err = m.err + (hit ? 1 : 0);
      if (n.err > top) n.err = top;
      n.cyc = m.cyc + 1;
      if (n.cyc > top) n.cyc = top;
      n.mis = hit;
      if (hit && !m.fev) begin
        n.fev = 1'b1;
        n.fec = m.cyc;
      end
      if (hit && n.err >= mx) n.st = 1;
      else if (n.cyc >= to) n.st = 2;
    end else begin
      n.mis = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input mdl_t e, input bit mis, input longint unsigned smp,
                     input longint unsigned err, input bit fev, input longint unsigned fec,
                     input longint unsigned st);
    chk_cnt++;
    if (mis !== e.mis || smp != e.smp || err != e.err || fev !== e.fev ||
        fec != e.fec || st != e.st) begin
      err_cnt++;
      $display("FAIL %s actual mis=%0d smp=%0d err=%0d fev=%0d fec=%0d st=%0d required mis=%0d smp=%0d err=%0d fev=%0d fec=%0d st=%0d",
               name, mis, smp, err, fev, fec, st, e.mis, e.smp, e.err, e.fev, e.fec, e.st);
    end
  endtask

  // Monitor: after every edge, compare each tracker against its predicted state.
  initial begin
    mdl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("sb_a", e, ifa.mismatch, 64'(ifa.samples), 64'(ifa.errors),
            ifa.first_err_valid, 64'(ifa.first_err_cycle), 64'(ifa.state));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("sb_b", e, ifb.mismatch, 64'(ifb.samples), 64'(ifb.errors),
            ifb.first_err_valid, 64'(ifb.first_err_cycle), 64'(ifb.state));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp("sb_c", e, ifc.mismatch, 64'(ifc.samples), 64'(ifc.errors),
            ifc.first_err_valid, 64'(ifc.first_err_cycle), 64'(ifc.state));
      end
    end
  end

  task automatic apply(input bit clr, input bit en, input bit care, input bit rv, input bit dv);
    clear = clr;
    ifa.sample_en = en; ifa.ref_care = care; ifa.ref_val = rv; ifa.dut_val = dv;
    ifb.sample_en = en; ifb.ref_care = care; ifb.ref_val = rv; ifb.dut_val = dv;
    ifc.sample_en = en; ifc.ref_care = care; ifc.ref_val = rv; ifc.dut_val = dv;
    ma = mdl_step(ma, 32, 1000, 100000, clr, en, care, rv, dv);
    mb = mdl_step(mb, 32, 3, 50, clr, en, care, rv, dv);
    mc = mdl_step(mc, 4, 15, 15, clr, en, care, rv, dv);
    qa.push_back(ma);
    qb.push_back(mb);
    qc.push_back(mc);
  endtask

  task automatic step(input bit clr, input bit en, input bit care, input bit rv, input bit dv);
    @(negedge clk);
    apply(clr, en, care, rv, dv);
  endtask

  // Wait until the last driven edge has been checked by the monitor.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_a_samples"}, 64'(ifa.samples), 0);
    chk({tag, "_a_errors"}, 64'(ifa.errors), 0);
    chk({tag, "_a_fev"}, 64'(ifa.first_err_valid), 0);
    chk({tag, "_a_fec"}, 64'(ifa.first_err_cycle), 0);
    chk({tag, "_a_mismatch"}, 64'(ifa.mismatch), 0);
    chk({tag, "_b_state"}, 64'(ifb.state), 0);
    chk({tag, "_c_errors"}, 64'(ifc.errors), 0);
  endtask

  // Assert areset between edges and check the outputs drop without a clock.
  task automatic async_reset();
    areset = 1'b1;
    #1;
    zero_checks("areset_mid");
    qa.delete(); qb.delete(); qc.delete();
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    @(negedge clk);
    areset = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit b;
    bit c;
    areset = 1'b1;
    clear  = 1'b0;
    ifa.sample_en = 1'b0; ifa.ref_care = 1'b0; ifa.ref_val = 1'b0; ifa.dut_val = 1'b0;
    ifb.sample_en = 1'b0; ifb.ref_care = 1'b0; ifb.ref_val = 1'b0; ifb.dut_val = 1'b0;
    ifc.sample_en = 1'b0; ifc.ref_care = 1'b0; ifc.ref_val = 1'b0; ifc.dut_val = 1'b0;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    repeat (2) @(posedge clk);
    #2;
    zero_checks("reset");
    @(negedge clk);
    areset = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 100 matching samples.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      b = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, 1'b1, b, b);
    end
    settle();
    chk("match_a_samples", 64'(ifa.samples), 100);
    chk("match_a_errors", 64'(ifa.errors), 0);
    chk("match_a_fev", 64'(ifa.first_err_valid), 0);
    chk("match_a_state", 64'(ifa.state), 0);
    chk("timeout_b_state", 64'(ifb.state), 2);
    chk("timeout_b_samples", 64'(ifb.samples), 50);
    chk("timeout_c_samples", 64'(ifc.samples), 15);

    // Single mismatch at cycle 7.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, 1'b1, b, (i == 7) ? ~b : b);
      if (i == 7) begin
        settle();
        chk("pulse_a_mismatch_set", 64'(ifa.mismatch), 1);
      end
      if (i == 8) begin
        settle();
        chk("pulse_a_mismatch_clr", 64'(ifa.mismatch), 0);
      end
    end
    settle();
    chk("first_a_errors", 64'(ifa.errors), 1);
    chk("first_a_fev", 64'(ifa.first_err_valid), 1);
    chk("first_a_fec", 64'(ifa.first_err_cycle), 7);

    // Don't-care reference with differing values.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      b = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, 1'b0, b, ~b);
    end
    settle();
    chk("dontcare_a_samples", 64'(ifa.samples), 10);
    chk("dontcare_a_errors", 64'(ifa.errors), 0);

    // Continuous mismatches: B trips at 3, C trips (not times out) at 15.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("trip_b_state", 64'(ifb.state), 1);
    chk("trip_b_errors", 64'(ifb.errors), 3);
    chk("trip_c_state", 64'(ifc.state), 1);
    chk("trip_c_errors", 64'(ifc.errors), 15);
    chk("trip_a_errors", 64'(ifa.errors), 20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("clear_b_state", 64'(ifb.state), 0);
    chk("clear_b_errors", 64'(ifb.errors), 0);
    chk("clear_b_samples", 64'(ifb.samples), 0);
    chk("clear_b_fev", 64'(ifb.first_err_valid), 0);

    // Timeout without clear, then samples must be ignored.
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("frozen_b_state", 64'(ifb.state), 2);
    chk("frozen_b_samples", 64'(ifb.samples), 0);
    chk("frozen_b_mismatch", 64'(ifb.mismatch), 0);

    // Mid-run async reset, then clear together with a sample.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      b = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, 1'b1, b, c);
    end
    settle();
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("clrsample_a_samples", 64'(ifa.samples), 0);
    chk("clrsample_a_errors", 64'(ifa.errors), 0);
    chk("clrsample_a_mismatch", 64'(ifa.mismatch), 0);

    // Random traffic with occasional clears and one async reset.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        settle();
        async_reset();
      end
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
